// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: RISC-V constants,
// the fetch buffer entry layout and a word-alignment helper.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush; head is shown combinationally
// and simultaneous push+pop is accepted when full.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (!full || pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order imem
// requests, buffers returned words and drops words made stale by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             req_fire, rsp_fire;
  logic             tag_push, tag_pop, data_push, data_pop;
  logic [31:0]      tag_pc;
  logic [CNT_W-1:0] tag_count, data_count;
  logic             tag_full, tag_empty, data_full, data_empty;
  fetch_entry_t     data_wr, data_head;

  // Outstanding requests plus buffered words never exceed the buffer size.
  assign imem_req_valid = !rst && (({1'b0, data_count} + {1'b0, out_cnt_q}) < CREDIT_MAX);
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (out_cnt_q != '0);

  assign tag_push  = req_fire && !tag_full;
  assign tag_pop   = rsp_fire && (drop_cnt_q == '0) && !tag_empty;
  assign data_pop  = inst_valid && inst_ready && !redirect_valid;
  assign data_push = tag_pop && !redirect_valid && (!data_full || data_pop);
  assign data_wr   = '{instruction: imem_rsp_data, pc: tag_pc};

  assign inst_valid  = !rst && !data_empty;
  assign instruction = inst_valid ? data_head.instruction : NOP_INST;
  assign inst_pc     = inst_valid ? data_head.pc : RESET_PC;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (tag_push),
    .pop   (tag_pop),
    .wdata (pc_q),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t)), .CNT_W(CNT_W)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (data_push),
    .pop   (data_pop),
    .wdata (data_wr),
    .rdata (data_head),
    .count (data_count),
    .full  (data_full),
    .empty (data_empty)
  );

  always_comb begin
    pc_d      = pc_q;
    out_cnt_d = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    else                                drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // Everything still in flight after this edge, including a request fired now, is stale.
      pc_d       = align_word(redirect_pc);
      drop_cnt_d = out_cnt_d;
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  a_drop_le_out: assert property (@(posedge clk) disable iff (rst)
    drop_cnt_q <= out_cnt_q);
  a_tags_match: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, drop_cnt_q} + {1'b0, tag_count}) == {1'b0, out_cnt_q});

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected {pc, word}
// entries; a monitor pops and compares on every decoder handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];

  int cmp_cnt    = 0;
  int err_cnt    = 0;
  int accepted   = 0;
  int req_budget = 0;
  int mem_lat    = 1;
  int cyc        = 0;
  bit rand_stall = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[7:0], addr[31:8]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) push_exp(start + 32'(4 * i));
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  task automatic wait_accepts(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (accepted >= req_budget) break;
      tick();
    end
  endtask

  // Instruction memory: in order, fixed latency, never stalls a response.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend_t p;
        p.due  = cyc + mem_lat;
        p.addr = imem_addr;
        pend_q.push_back(p);
        accepted++;
      end
      @(posedge clk);
      #2;
      cyc++;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      imem_req_ready = (accepted < req_budget) && (!rand_stall || ($urandom_range(0, 1) == 1));
    end
  end

  // Monitor: every delivered word must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_word: got pc %h with no word expected", inst_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("instruction", instruction, e.inst);
        end
      end
    end
  end

  int start_acc;

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instruction", instruction, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_inst_valid", 32'(inst_valid), 32'd0);

    // 1: sequential stream from reset
    tick();
    inst_ready = 1'b1;
    push_seq(32'h0, 8);
    req_budget = accepted + 8;
    wait_drain("t1_drain", 200);

    // 2: decoder stall fills the buffer and throttles requests
    inst_ready = 1'b0;
    start_acc  = accepted;
    req_budget = accepted + 6;
    repeat (10) tick();
    @(negedge clk);
    check("t2_buffered", 32'(accepted - start_acc), 32'd2);
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_inst_valid", 32'(inst_valid), 32'd1);
    check("t2_head_pc", inst_pc, 32'h20);
    tick();
    push_seq(32'h20, 6);
    inst_ready = 1'b1;
    wait_drain("t2_drain", 200);

    // 3: redirect with two requests in flight
    mem_lat    = 3;
    req_budget = accepted + 2;
    wait_accepts(20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    req_budget     = accepted + 2;
    push_seq(32'h100, 2);
    @(negedge clk);
    check("t3_inst_valid", 32'(inst_valid), 32'd0);
    check("t3_addr", imem_addr, 32'h100);
    wait_drain("t3_drain", 200);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_misaligned_addr", imem_addr, 32'h100);
    push_exp(32'h100);
    req_budget = accepted + 1;
    wait_drain("t3b_drain", 200);

    // 4: redirect coincides with a request and a response
    mem_lat    = 1;
    req_budget = accepted + 2;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check("t4_coincide", {29'd0, imem_req_valid, imem_req_ready, imem_rsp_valid}, 32'd7);
    tick();
    redirect_valid = 1'b0;
    req_budget     = accepted + 2;
    push_seq(32'h200, 2);
    @(negedge clk);
    check("t4_inst_valid", 32'(inst_valid), 32'd0);
    wait_drain("t4_drain", 200);

    // 5: one-cycle reset with words buffered
    inst_ready = 1'b0;
    req_budget = accepted + 2;
    repeat (8) tick();
    @(negedge clk);
    check("t5_pre_head", inst_pc, 32'h208);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("t5_rst_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_inst_valid", 32'(inst_valid), 32'd0);
    check("t5_addr", imem_addr, 32'h0);
    tick();
    inst_ready = 1'b1;
    push_seq(32'h0, 3);
    req_budget = accepted + 3;
    wait_drain("t5_drain", 200);

    // 6: PC wrap with random memory and decoder stalls
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t6_addr", imem_addr, 32'hFFFF_FFF8);
    tick();
    rand_stall = 1'b1;
    push_seq(32'hFFFF_FFF8, 4);
    req_budget = accepted + 4;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      inst_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    inst_ready = 1'b1;
    rand_stall = 1'b0;
    wait_drain("t6_drain", 50);
    @(negedge clk);
    check("t6_final_addr", imem_addr, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
